// File: rtl/alsu_pkg.sv
// rtl/alsu_pkg.sv - shared ALSU op codes, shift modes and accumulator states
package alsu_pkg;

  // Accumulator operation codes (op[2] set means a shift/rotate)
  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_LOAD_E = 3'b001;
  localparam logic [2:0] OP_LOAD_D = 3'b010;
  localparam logic [2:0] OP_CLR    = 3'b011;
  localparam logic [2:0] OP_SHL    = 3'b100;
  localparam logic [2:0] OP_SHR    = 3'b101;
  localparam logic [2:0] OP_ROL    = 3'b110;
  localparam logic [2:0] OP_ROR    = 3'b111;

  // Single-bit shift modes; equal to op[1:0] of the shift op codes
  localparam logic [1:0] SH_SHL = 2'b00;
  localparam logic [1:0] SH_SHR = 2'b01;
  localparam logic [1:0] SH_ROL = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // True for the four shift/rotate op codes
  function automatic logic is_shift_op(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/alsu_shift_step.sv
// rtl/alsu_shift_step.sv - combinational one-bit shift/rotate of the accumulator
module alsu_shift_step
  import alsu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [1:0]       i_mode,
  input  logic             i_il,
  input  logic             i_ir,
  output logic [WIDTH-1:0] o_acc,
  output logic             o_out_bit
);

  // Select the shifted value and the bit leaving the register
  always_comb begin
    o_acc     = i_acc;
    o_out_bit = 1'b0;
    case (i_mode)
      SH_SHL: begin
        o_acc     = {i_acc[WIDTH-2:0], i_il};
        o_out_bit = i_acc[WIDTH-1];
      end
      SH_SHR: begin
        o_acc     = {i_ir, i_acc[WIDTH-1:1]};
        o_out_bit = i_acc[0];
      end
      SH_ROL: begin
        o_acc     = {i_acc[WIDTH-2:0], i_acc[WIDTH-1]};
        o_out_bit = i_acc[WIDTH-1];
      end
      default: begin
        o_acc     = {i_acc[0], i_acc[WIDTH-1:1]};
        o_out_bit = i_acc[0];
      end
    endcase
  end

endmodule

// File: rtl/alsu_accumulator.sv
// rtl/alsu_accumulator.sv - ALSU accumulator with flags and multi-cycle shift/rotate
module alsu_accumulator
  import alsu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] le_e,
  input  logic [WIDTH-1:0] au_d,
  input  logic             au_cout,
  input  logic [CNT_W-1:0] shamt,
  input  logic             il,
  input  logic             ir,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_mode;
  logic             r_il;
  logic             r_ir;

  logic [1:0]       w_mode;
  logic             w_il;
  logic             w_ir;
  logic [WIDTH-1:0] w_next_acc;
  logic             w_out_bit;

  // First step uses the live request; later steps use the values latched at accept
  always_comb begin
    w_mode = r_mode;
    w_il   = r_il;
    w_ir   = r_ir;
    if (r_state == ST_IDLE) begin
      w_mode = op[1:0];
      w_il   = il;
      w_ir   = ir;
    end
  end

  alsu_shift_step #(
    .WIDTH(WIDTH)
  ) u_shift_step (
    .i_acc    (r_acc),
    .i_mode   (w_mode),
    .i_il     (w_il),
    .i_ir     (w_ir),
    .o_acc    (w_next_acc),
    .o_out_bit(w_out_bit)
  );

  // Control FSM: accept an op in IDLE, step remaining shifts in SHIFT, pulse done at the end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_mode  <= SH_SHL;
      r_il    <= 1'b0;
      r_ir    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            case (op)
              OP_NOP: r_done <= 1'b1;
              OP_LOAD_E: begin
                r_acc   <= le_e;
                r_carry <= 1'b0;
                r_done  <= 1'b1;
              end
              OP_LOAD_D: begin
                r_acc   <= au_d;
                r_carry <= au_cout;
                r_done  <= 1'b1;
              end
              OP_CLR: begin
                r_acc   <= '0;
                r_carry <= 1'b0;
                r_done  <= 1'b1;
              end
              default: begin
                if (shamt != '0) begin
                  r_acc   <= w_next_acc;
                  r_carry <= w_out_bit;
                end
                if (shamt > CNT_W'(1)) begin
                  // r_cnt holds the steps still to perform after this edge
                  r_state <= ST_SHIFT;
                  r_cnt   <= shamt - CNT_W'(1);
                  r_mode  <= op[1:0];
                  r_il    <= il;
                  r_ir    <= ir;
                end else begin
                  r_done  <= 1'b1;
                end
              end
            endcase
          end
        end
        default: begin
          r_acc   <= w_next_acc;
          r_carry <= w_out_bit;
          r_cnt   <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign in_ready = (r_state == ST_IDLE);
  assign busy     = (r_state == ST_SHIFT);
  assign acc      = r_acc;
  assign carry    = r_carry;
  assign zero     = (r_acc == '0);
  assign done     = r_done;

endmodule

// File: tb/tb_alsu_accumulator.sv
// tb/tb_alsu_accumulator.sv - scoreboard bench for alsu_accumulator
module tb_alsu_accumulator;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [3:0] le_e;
  logic [3:0] au_d;
  logic       au_cout;
  logic [1:0] shamt;
  logic       il;
  logic       ir;
  logic [3:0] acc;
  logic       carry;
  logic       zero;
  logic       busy;
  logic       done;

  typedef struct packed {
    logic [3:0] acc;
    logic       carry;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   errors;

  alsu_accumulator #(
    .WIDTH(4),
    .CNT_W(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op      (op),
    .le_e    (le_e),
    .au_d    (au_d),
    .au_cout (au_cout),
    .shamt   (shamt),
    .il      (il),
    .ir      (ir),
    .acc     (acc),
    .carry   (carry),
    .zero    (zero),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got acc %0h carry %0b expected no done", acc, carry);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_acc", 32'(acc), 32'(e.acc));
        check("sb_carry", 32'(carry), 32'(e.carry));
        check("sb_zero", 32'(zero), 32'(e.acc == 4'b0000));
      end
    end
  end

  // Issue one op at a negedge once in_ready is seen; returns 1 time unit after the accept edge
  task automatic issue(input logic [2:0] o, input logic [3:0] e, input logic [3:0] d,
                       input logic c, input logic [1:0] sh, input logic fl, input logic fr,
                       input bit exp_done, input logic [3:0] ea, input logic ec);
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (in_ready !== 1'b1) begin
      check("ready_timeout", 32'(in_ready), 32'd1);
    end
    op       = o;
    le_e     = e;
    au_d     = d;
    au_cout  = c;
    shamt    = sh;
    il       = fl;
    ir       = fr;
    in_valid = 1'b1;
    if (exp_done) sb_q.push_back('{acc: ea, carry: ec});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = 3'b000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    in_valid = 1'b1;
    op       = 3'b001;
    le_e     = 4'b1111;
    au_d     = 4'b1111;
    au_cout  = 1'b1;
    shamt    = 2'd0;
    il       = 1'b0;
    ir       = 1'b0;

    // Reset with a pending request
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_acc", 32'(acc), 32'h0);
    check("rst_carry", 32'(carry), 32'h0);
    check("rst_zero", 32'(zero), 32'h1);
    check("rst_done", 32'(done), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);

    // LOAD_E 0001 (5 AND 3), done exactly one cycle
    issue(3'b001, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0);
    @(negedge clk);
    check("loade_done", 32'(done), 32'h1);
    @(negedge clk);
    check("loade_done_one", 32'(done), 32'h0);

    // LOAD_D 0000 with carry
    issue(3'b010, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1);

    // ROL 1001 by 3: 0011 c1, 0110 c0, 1100 c0
    issue(3'b001, 4'b1001, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'b1001, 1'b0);
    issue(3'b110, 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 4'b1100, 1'b0);
    @(negedge clk);
    check("rol_s1_acc", 32'(acc), 32'h3);
    check("rol_s1_carry", 32'(carry), 32'h1);
    check("rol_s1_busy", 32'(busy), 32'h1);
    check("rol_s1_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    check("rol_s2_acc", 32'(acc), 32'h6);
    check("rol_s2_busy", 32'(busy), 32'h1);
    check("rol_s2_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    check("rol_s3_busy", 32'(busy), 32'h0);
    check("rol_s3_done", 32'(done), 32'h1);
    check("rol_s3_ready", 32'(in_ready), 32'h1);

    // SHR 0001 ir=1 by 2, with an ignored CLR request mid-shift
    issue(3'b001, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0);
    issue(3'b101, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 4'b1100, 1'b0);
    check("shr_s1_acc", 32'(acc), 32'h8);
    check("shr_s1_carry", 32'(carry), 32'h1);
    in_valid = 1'b1;
    op       = 3'b011;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = 3'b000;
    @(negedge clk);
    check("shr_s2_acc", 32'(acc), 32'hc);
    check("shr_s2_carry", 32'(carry), 32'h0);
    @(negedge clk);
    check("shr_clr_ignored", 32'(acc), 32'hc);

    // Reset during SHL 0111 by 3: no done pulse afterwards
    issue(3'b001, 4'b0111, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'b0111, 1'b0);
    issue(3'b100, 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    @(negedge clk);
    check("shl_s1_acc", 32'(acc), 32'he);
    check("shl_s1_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_acc", 32'(acc), 32'h0);
    check("midrst_carry", 32'(carry), 32'h0);
    check("midrst_zero", 32'(zero), 32'h1);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_ready", 32'(in_ready), 32'h1);
    check("midrst_done", 32'(done), 32'h0);
    repeat (4) @(negedge clk);

    // shamt=0 leaves acc/carry alone; shamt=1 and ROR by 2 finish quickly
    issue(3'b001, 4'b1010, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b0);
    issue(3'b100, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 4'b1010, 1'b0);
    @(negedge clk);
    check("sh0_done", 32'(done), 32'h1);
    issue(3'b100, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 4'b0101, 1'b1);
    issue(3'b111, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 4'b0101, 1'b0);
    // Back-to-back loads: one per cycle
    issue(3'b010, 4'b0000, 4'b0110, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b1);
    issue(3'b011, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
    repeat (5) @(negedge clk);

    check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
